// File: rtl/nand_tt_pkg.sv
// Shared types and helpers for the 2-input NAND truth-table checker.
package nand_tt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  localparam int unsigned NUM_VEC = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 4;

  // Golden response of the gate under test.
  function automatic logic nand_exp(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/nand_tt_timer.sv
// Loadable down-counter that times the settle window between drive and sample.
module nand_tt_timer
  import nand_tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // High in the enabled cycle whose decrement brings the count to zero.
  assign zero_c = en && (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/nand_tt_checker.sv
// BIST sequencer: sweeps a 2-input gate through all vectors and checks c
// against the NAND truth table, reporting per-vector and total errors.
module nand_tt_checker
  import nand_tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned NUM_PASSES = 1,
  parameter int unsigned ERR_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               c,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [NUM_VEC-1:0] err_vec
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(NUM_PASSES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  if (SETTLE_CYC > (2 ** CNT_W) - 1) begin : g_bad_settle
    $error("SETTLE_CYC must be in 0..15");
  end
  if ((NUM_PASSES < 1) || (NUM_PASSES > (2 ** CNT_W) - 1)) begin : g_bad_passes
    $error("NUM_PASSES must be in 1..15");
  end
  if (ERR_W < 1) begin : g_bad_errw
    $error("ERR_W must be at least 1");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic               a_d, b_d, busy_d, done_d, pass_d;
  logic [ERR_W-1:0]   err_cnt_d;
  logic [NUM_VEC-1:0] err_vec_d;
  logic               tmr_load_c, tmr_en_c, tmr_zero_c;
  logic               mismatch_c;

  nand_tt_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_c),
    .en       (tmr_en_c),
    .load_val (SETTLE_LD),
    .zero_c   (tmr_zero_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pass_cnt_q <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      err_vec    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pass_cnt_q <= pass_cnt_d;
      a          <= a_d;
      b          <= b_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_cnt    <= err_cnt_d;
      err_vec    <= err_vec_d;
    end
  end

  // X/Z on c counts as a mismatch in simulation.
  assign mismatch_c = (c !== nand_exp(a, b));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pass_cnt_d = pass_cnt_q;
    a_d        = a;
    b_d        = b;
    busy_d     = busy;
    done_d     = 1'b0;
    pass_d     = pass;
    err_cnt_d  = err_cnt;
    err_vec_d  = err_vec;
    tmr_load_c = 1'b0;
    tmr_en_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_cnt_d  = '0;
          err_vec_d  = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          pass_cnt_d = '0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        a_d        = idx_q[1];
        b_d        = idx_q[0];
        tmr_load_c = 1'b1;
        busy_d     = 1'b1;
        state_d    = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        tmr_en_c = 1'b1;
        if (tmr_zero_c) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (mismatch_c) begin
          err_vec_d[idx_q] = 1'b1;
          if (err_cnt != ERR_MAX) begin
            err_cnt_d = err_cnt + ERR_W'(1);
          end
        end
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = DRIVE;
        end else if (pass_cnt_q < LAST_PASS) begin
          idx_d      = '0;
          pass_cnt_d = pass_cnt_q + CNT_W'(1);
          state_d    = DRIVE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_cnt == '0);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/nand_tt_checker.md
Name: nand_tt_checker

Overview:
- Self-checking truth-table sequencer for the 2-input NAND gate stage.
- Upstream role: drives operands a,b through all four input vectors (00,01,10,11).
- Downstream role: samples the gate's output c after a settle window and compares it against the golden NAND value.
- Reports per-vector failures, a saturating error count and an overall pass flag; used as an on-chip/bench BIST wrapper around any 2-input gate cell.

Parameters:
- SETTLE_CYC, 2, clock cycles to wait between driving a vector and sampling c (range 0..15).
- NUM_PASSES, 1, number of complete 4-vector sweeps per start (range 1..15).
- ERR_W, 4, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a test run; sampled only in IDLE.
- c  input  1  output of the gate under test.
- a  output  1  operand A to the gate, registered.
- b  output  1  operand B to the gate, registered.
- busy  output  1  high from the cycle after start is accepted until DONE is exited.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  1 when the last run finished with zero errors; held until the next start.
- err_cnt  output  ERR_W  mismatches in the last/current run, saturating at 2^ERR_W-1.
- err_vec  output  4  bit i set if vector i ({a,b}=i) failed in any pass.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; a=b=0; busy=done=pass=0; err_cnt=0; err_vec=0; vector index=0; pass counter=0; settle timer=0. Reset mid-run aborts immediately, with no done pulse.
- IDLE: on start=1 → clear err_cnt, err_vec and pass; set idx=0 and pass counter=0; go to DRIVE.
- DRIVE (1 cycle): register a=idx[1], b=idx[0]; load timer=SETTLE_CYC; busy=1.
  - If SETTLE_CYC=0 → go to SAMPLE.
  - Otherwise → go to SETTLE.
- SETTLE: decrement the timer each cycle; go to SAMPLE on the cycle the timer reaches 0 (exactly SETTLE_CYC cycles in SETTLE).
- SAMPLE (1 cycle): expected = ~(a & b).
  - Mismatch: any c != expected, including X/Z in simulation (use case-inequality in the bench model).
  - On mismatch: err_vec[idx] set; err_cnt incremented unless already all-ones (saturate, no wrap).
- Index advance after SAMPLE:
  - idx<3: idx+1 → DRIVE.
  - idx=3 and pass counter < NUM_PASSES-1: idx=0, pass counter+1 → DRIVE.
  - Otherwise → DONE.
- DONE (1 cycle): done=1; pass=(err_cnt==0), registered on the same edge (visible together with done); busy=0 on the next edge; → IDLE.
- Latency: a/b change on the edge after the cycle start is seen high.
  - Per vector: 1 + SETTLE_CYC + 1 cycles.
  - Total start-to-done = NUM_PASSES*4*(SETTLE_CYC+2) + 1 cycles.
  - Defaults give done 17 cycles after start.
- Start handling: start while busy is ignored, with no restart and no effect on counters. Start held high continuously re-triggers only from IDLE, so back-to-back runs are separated by the DONE cycle.
- Hold behaviour: a,b hold their last vector (1,1) after a run until the next start or reset. err_cnt/err_vec hold their final values in IDLE.
- Width rules: idx is 2 bits with natural wrap 3→0 handled explicitly. The pass counter and timer are 4 bits, and parameters outside range are illegal (assert in simulation).

Decomposition:
- Package nand_tt_pkg:
  - state enum {IDLE, DRIVE, SETTLE, SAMPLE, DONE};
  - constant NUM_VEC=4;
  - function nand_exp(a,b) giving the golden value.
- One natural sub-module: nand_tt_timer, a loadable 4-bit down-counter with load, en and zero flag used for the settle window. All other logic lives in the FSM.

Test Plan:
- Good NAND on c, defaults, start pulse → a,b sequence 00,01,10,11; done at start+17; pass=1, err_cnt=0, err_vec=4'b0000.
- c stuck at 1 → only vector 3 fails: err_vec=4'b1000, err_cnt=1, pass=0.
- AND gate instead of NAND → err_vec=4'b1111, err_cnt=4, pass=0.
- Saturation: NUM_PASSES=4, ERR_W=3, c stuck at 0 → 12 raw mismatches; err_cnt=7 (saturated); err_vec=4'b0111; done at start+65.
- Start held high for 5 cycles mid-run → run not restarted, done still at start+17. Then rst_n pulsed low during SETTLE of vector 2 → all outputs 0 immediately, no done pulse, next start runs cleanly.
- SETTLE_CYC=0 with a good gate → done at start+9, pass=1. A gate model with 1-cycle output delay and SETTLE_CYC=0 → at least one mismatch flagged, pass=0.
